// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for Instruction_FD: ld, sd, add, sub, addi.
// Define BRANCH_EN to also decode beq/bne, with PC-relative branch targets.
module multicycle_control_unit #(
   parameter int unsigned             PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0]     RESET_PC  = '0,
   parameter int unsigned             CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [31:0]          instruction,
   input  logic                 zero,
   output logic [PC_WIDTH-1:0]  PC_add,
   output logic                 PC_load,
   output logic                 WE_mem,
   output logic                 WE_reg,
   output logic [1:0]           OP_MEM_I,
   output logic                 ADD_SUB,
   output logic                 busy,
   output logic                 halted,
   output logic                 illegal,
   output logic [CNT_WIDTH-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_NEXT,
      S_HALT
   } state_t;

   state_t               state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [CNT_WIDTH-1:0] ret_q, ret_d;
   logic [31:0]          ir_q, ir_d;
   logic                 ill_q, ill_d;
   logic                 we_mem_q, we_mem_d;
   logic                 we_reg_q, we_reg_d;
   logic [1:0]           op_q, op_d;
   logic                 as_q, as_d;
   logic                 load_q, load_d;

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       is_ld, is_sd, is_add, is_sub, is_addi, is_br, legal;

   assign opc = instruction[6:0];
   assign f3  = instruction[14:12];
   assign f7  = instruction[31:25];

   assign is_ld   = (opc == 7'b0000011) && (f3 == 3'b011);
   assign is_sd   = (opc == 7'b0100011) && (f3 == 3'b011);
   assign is_add  = (opc == 7'b0110011) && (f3 == 3'b000)
                    && (f7 == 7'b0000000);
   assign is_sub  = (opc == 7'b0110011) && (f3 == 3'b000)
                    && (f7 == 7'b0100000);
   assign is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
`ifdef BRANCH_EN
   assign is_br   = (opc == 7'b1100011)
                    && ((f3 == 3'b000) || (f3 == 3'b001));
`else
   assign is_br   = 1'b0;
`endif
   assign legal = is_ld | is_sd | is_add | is_sub | is_addi | is_br;

`ifdef BRANCH_EN
   // B-immediate is a byte offset; the PC counts words.
   logic [12:0]         bimm;
   logic [PC_WIDTH-1:0] br_off;
   logic                br_taken;

   assign bimm = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign br_off = PC_WIDTH'(
      $signed({{(PC_WIDTH-13){bimm[12]}}, bimm}) >>> 2);
   assign br_taken = (ir_q[6:0] == 7'b1100011)
                     && (ir_q[12] ? !zero : zero);
`endif

   logic unused_ok;
   assign unused_ok = ^{zero, ir_q};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ret_d    = ret_q;
      ir_d     = ir_q;
      ill_d    = ill_q;
      we_mem_d = 1'b0;
      we_reg_d = 1'b0;
      op_d     = op_q;
      as_d     = as_q;
      load_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               load_d  = 1'b1;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            ir_d = instruction;
            if (instruction == 32'h0) begin
               state_d = S_HALT;
            end else if (!legal) begin
               state_d = S_HALT;
               ill_d   = 1'b1;
            end else begin
               state_d = S_EXEC;
               unique case (1'b1)
                  is_ld: begin
                     op_d = 2'd1; as_d = 1'b0; we_reg_d = 1'b1;
                  end
                  is_sd: begin
                     op_d = 2'd1; as_d = 1'b0; we_mem_d = 1'b1;
                  end
                  is_add: begin
                     op_d = 2'd0; as_d = 1'b0; we_reg_d = 1'b1;
                  end
                  is_sub: begin
                     op_d = 2'd0; as_d = 1'b1; we_reg_d = 1'b1;
                  end
                  is_addi: begin
                     op_d = 2'd2; as_d = 1'b0; we_reg_d = 1'b1;
                  end
                  is_br: begin
                     op_d = 2'd0; as_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         S_EXEC: state_d = S_NEXT;
         S_NEXT: begin
`ifdef BRANCH_EN
            if (br_taken) pc_d = pc_q + br_off;
            else          pc_d = pc_q + PC_WIDTH'(1);
`else
            pc_d = pc_q + PC_WIDTH'(1);
`endif
            ret_d   = ret_q + CNT_WIDTH'(1);
            load_d  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         ret_q    <= '0;
         ir_q     <= '0;
         ill_q    <= 1'b0;
         we_mem_q <= 1'b0;
         we_reg_q <= 1'b0;
         op_q     <= 2'd0;
         as_q     <= 1'b0;
         load_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ret_q    <= ret_d;
         ir_q     <= ir_d;
         ill_q    <= ill_d;
         we_mem_q <= we_mem_d;
         we_reg_q <= we_reg_d;
         op_q     <= op_d;
         as_q     <= as_d;
         load_q   <= load_d;
      end
   end

   assign PC_add   = pc_q;
   assign PC_load  = load_q;
   assign WE_mem   = we_mem_q;
   assign WE_reg   = we_reg_q;
   assign OP_MEM_I = op_q;
   assign ADD_SUB  = as_q;
   assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);
   assign halted   = (state_q == S_HALT);
   assign illegal  = ill_q;
   assign retired  = ret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with a small datapath model.
// ROM, register file and data memory are modelled here and driven by DUT controls.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst, start, zero;
   logic [31:0] instruction;
   logic [31:0] PC_add;
   logic        PC_load, WE_mem, WE_reg, ADD_SUB;
   logic [1:0]  OP_MEM_I;
   logic        busy, halted, illegal;
   logic [31:0] retired;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] rom [16];
   logic [31:0] mem [16];
   logic [31:0] rf  [32];

   always #5 clk = ~clk;

   assign instruction = rom[PC_add[3:0]];

   multicycle_control_unit dut (
      .clk(clk), .rst(rst), .start(start),
      .instruction(instruction), .zero(zero),
      .PC_add(PC_add), .PC_load(PC_load),
      .WE_mem(WE_mem), .WE_reg(WE_reg),
      .OP_MEM_I(OP_MEM_I), .ADD_SUB(ADD_SUB),
      .busy(busy), .halted(halted),
      .illegal(illegal), .retired(retired)
   );

   function automatic logic [31:0] enc_i(
      input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd,
      input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(
      input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_r(
      input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [4:0] rd);
      return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Datapath model: acts on the controls present just before the edge.
   task automatic model_step();
      logic [31:0] ins, a, b, ii, si, v;
      logic [4:0]  rd;
      ins = rom[PC_add[3:0]];
      a   = rf[ins[19:15]];
      b   = rf[ins[24:20]];
      rd  = ins[11:7];
      ii  = {{20{ins[31]}}, ins[31:20]};
      si  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      if (WE_reg && rd != 5'd0) begin
         case (OP_MEM_I)
            2'd1:    v = mem[4'(a + ii)];
            2'd2:    v = a + ii;
            default: v = ADD_SUB ? a - b : a + b;
         endcase
         rf[rd] = v;
      end
      if (WE_mem) mem[4'(a + si)] = b;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_halt(input string tag, input int max);
      int n = 0;
      while (!halted && n < max) begin
         tick();
         n++;
      end
      check(tag, {31'd0, halted}, 32'd1);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = 32'h0;
   endtask

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] BEQ8 =
      {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b0100, 1'b0, 7'b1100011};

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; zero = 1'b0;
      clear_rom();
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      mem[1] = 32'd10;
      mem[2] = 32'd20;
      rom[0] = enc_i(12'd1, 5'd0, 3'b011, 5'd1, 7'b0000011);

      tick(); tick();
      check("rst_pc",      PC_add, 32'd0);
      check("rst_retired", retired, 32'd0);
      check("rst_busy",    {31'd0, busy}, 32'd0);
      check("rst_halted",  {31'd0, halted}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      check("rst_we",      {30'd0, WE_mem, WE_reg}, 32'd0);
      check("rst_op",      {29'd0, OP_MEM_I, ADD_SUB}, 32'd0);
      check("rst_load",    {31'd0, PC_load}, 32'd0);

      // single ld, cycle by cycle
      rst = 1'b0;
      pulse_start();
      check("t1_fetch_pc",   PC_add, 32'd0);
      check("t1_fetch_load", {31'd0, PC_load}, 32'd1);
      check("t1_fetch_busy", {31'd0, busy}, 32'd1);
      tick();
      check("t1_dec_load", {31'd0, PC_load}, 32'd0);
      check("t1_dec_we",   {31'd0, WE_reg}, 32'd0);
      tick();
      check("t1_exec_we",   {31'd0, WE_reg}, 32'd1);
      check("t1_exec_wem",  {31'd0, WE_mem}, 32'd0);
      check("t1_exec_op",   {30'd0, OP_MEM_I}, 32'd1);
      tick();
      check("t1_next_we",   {31'd0, WE_reg}, 32'd0);
      check("t1_next_hold", {30'd0, OP_MEM_I}, 32'd1);
      check("t1_next_ret",  retired, 32'd0);
      tick();
      check("t1_f2_pc",   PC_add, 32'd1);
      check("t1_f2_ret",  retired, 32'd1);
      check("t1_f2_load", {31'd0, PC_load}, 32'd1);
      wait_halt("t1_halt", 20);
      check("t1_illegal", {31'd0, illegal}, 32'd0);
      check("t1_x1",      rf[1], 32'd10);

      // six-instruction program ending on word 0
      do_reset();
      clear_rom();
      rom[0] = enc_i(12'd1, 5'd0, 3'b011, 5'd1, 7'b0000011);
      rom[1] = enc_i(12'd2, 5'd0, 3'b011, 5'd2, 7'b0000011);
      rom[2] = enc_r(7'b0000000, 5'd2, 5'd1, 5'd3);
      rom[3] = enc_r(7'b0100000, 5'd1, 5'd3, 5'd4);
      rom[4] = enc_s(12'd3, 5'd3, 5'd0);
      rom[5] = enc_s(12'd4, 5'd4, 5'd0);
      pulse_start();
      wait_halt("t2_halt", 100);
      check("t2_mem3",    mem[3], 32'd30);
      check("t2_mem4",    mem[4], 32'd20);
      check("t2_illegal", {31'd0, illegal}, 32'd0);
      check("t2_retired", retired, 32'd6);
      check("t2_pc",      PC_add, 32'd6);
      check("t2_busy",    {31'd0, busy}, 32'd0);

      // addi then sd
      do_reset();
      clear_rom();
      rom[0] = enc_i(12'd10, 5'd4, 3'b000, 5'd9, 7'b0010011);
      rom[1] = enc_s(12'd9, 5'd9, 5'd0);
      pulse_start();
      tick(); tick();
      check("t3_addi_op", {30'd0, OP_MEM_I}, 32'd2);
      check("t3_addi_we", {31'd0, WE_reg}, 32'd1);
      wait_halt("t3_halt", 40);
      check("t3_mem9",    mem[9], 32'd30);
      check("t3_retired", retired, 32'd2);

      // unsupported opcode at PC=2
      do_reset();
      clear_rom();
      rom[0] = NOP;
      rom[1] = NOP;
      rom[2] = 32'h0000_007F;
      pulse_start();
      wait_halt("t4_halt", 40);
      check("t4_illegal", {31'd0, illegal}, 32'd1);
      check("t4_pc",      PC_add, 32'd2);
      check("t4_retired", retired, 32'd2);
      pulse_start();
      tick(); tick();
      check("t4_stay_halt", {31'd0, halted}, 32'd1);
      check("t4_stay_busy", {31'd0, busy}, 32'd0);
      check("t4_stay_pc",   PC_add, 32'd2);
      do_reset();
      check("t4_rst_ill",  {31'd0, illegal}, 32'd0);
      check("t4_rst_halt", {31'd0, halted}, 32'd0);
      check("t4_rst_pc",   PC_add, 32'd0);
      check("t4_rst_ret",  retired, 32'd0);

      // reset during the EXEC of sd, after one retired instruction
      clear_rom();
      rom[0] = NOP;
      rom[1] = enc_s(12'd3, 5'd3, 5'd0);
      pulse_start();
      n = 0;
      while (!WE_mem && n < 20) begin
         tick();
         n++;
      end
      check("t5_we_seen", {31'd0, WE_mem}, 32'd1);
      check("t5_pre_ret", retired, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_wem",   {31'd0, WE_mem}, 32'd0);
      check("t5_pc",    PC_add, 32'd0);
      check("t5_ret",   retired, 32'd0);
      check("t5_busy",  {31'd0, busy}, 32'd0);
      tick();
      check("t5_idle", {30'd0, busy, halted}, 32'd0);

      // beq at PC=5, B-imm=+8
      do_reset();
      clear_rom();
      for (int i = 0; i < 5; i++) rom[i] = NOP;
      rom[5] = BEQ8;
`ifdef BRANCH_EN
      zero = 1'b1;
      pulse_start();
      wait_halt("t6_taken_halt", 60);
      check("t6_taken_pc",  PC_add, 32'd7);
      check("t6_taken_ret", retired, 32'd6);
      check("t6_taken_ill", {31'd0, illegal}, 32'd0);
      do_reset();
      zero = 1'b0;
      pulse_start();
      wait_halt("t6_nt_halt", 60);
      check("t6_nt_pc",  PC_add, 32'd6);
      check("t6_nt_ret", retired, 32'd6);
`else
      zero = 1'b1;
      pulse_start();
      wait_halt("t6_halt", 60);
      check("t6_illegal", {31'd0, illegal}, 32'd1);
      check("t6_pc",      PC_add, 32'd5);
      check("t6_ret",     retired, 32'd5);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
